tl_egress_merger: RTL and testbench
===================================

# tl_egress_merger

Transmit-side merger of the PCIe transaction-layer model. It drains the four per-class output queues (classes 0-3) with a round-robin arbiter and serializes their 12-bit words onto a single downstream link FIFO, honouring that FIFO's almost-full backpressure. It also keeps a per-class count of forwarded words, readable by index while the block is idle. It is the reverse of the class demultiplexer that fills those queues.

## Interface
- WIDTH, 12, word width; bits [11:10] carry the class and pass through unmodified.
- CNT_W, 5, width of each per-class forwarded-word counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- init  in  1  synchronous re-initialization request.
- empty0..empty3  in  1 each  empty flag of class queue k.
- data_in0..data_in3  in  WIDTH each  read data of class queue k; valid the cycle after pop_k.
- pop0..pop3  out  1 each  read strobe to class queue k; at most one high per cycle.
- alm_full_dn  in  1  almost-full flag of the downstream link FIFO.
- push_out  out  1  write strobe to the downstream FIFO.
- data_out  out  WIDTH  word written when push_out=1.
- idx  in  2  selects which class counter drives count.
- count  out  CNT_W  forwarded-word counter of class idx.
- count_valid  out  1  high while the FSM is in IDLE.
- state  out  2  FSM state: INIT=0, IDLE=1, ACTIVE=2.

## Operation
- FSM states:
  - INIT: clears all counters, sets rr_ptr=0 and clears the pipeline. Always exits to IDLE after one cycle.
  - IDLE: moves to ACTIVE when any empty_k=0.
  - ACTIVE: moves to IDLE when all empty_k=1 and both pipeline stages are empty.
- init=1 in any state: next state is INIT. Any in-flight words are discarded and no push occurs. init takes priority over all other events.
- Grant (combinational from registered state):
  - A grant is made only when state=ACTIVE, alm_full_dn=0 and init=0.
  - The grant goes to the first non-empty queue searching rr_ptr, rr_ptr+1, … (mod 4).
  - pop_k=1 for the granted queue k only.
  - After a grant to k, rr_ptr <= (k+1) mod 4. With no grant, rr_ptr holds.
- Single non-empty queue: back-to-back pops of that queue are allowed on consecutive cycles.
- Pipeline:
  - Stage 1 registers the granted class and a valid bit at the edge ending the pop cycle.
  - Stage 2 captures data_in[class] into data_out, asserts push_out and increments counter[class].
- Counters: CNT_W-bit, wrap 31 -> 0, no saturation. count = counter[idx] in every state. count_valid = (state==IDLE).

## Timing
- Reset values (asynchronous on reset=1): state=INIT, pop0..3=0, push_out=0, data_out=0, all counters=0, rr_ptr=0, count_valid=0.
- Reset sequence:
  - While reset is high the FSM stays in INIT.
  - First edge after reset is released: INIT -> IDLE.
  - The first grant can occur on the edge after IDLE -> ACTIVE.
- Latency: pop_k high in cycle N -> push_out=1 with data_out = queue k's word in cycle N+2.
- Throughput: one word per cycle sustained.
- Backpressure:
  - alm_full_dn is sampled only when issuing a grant. Words already in flight (up to 2) are still pushed.
  - The downstream almost-full threshold must therefore leave at least 2 free slots.
- Counter update: counter[class] increments on the same edge that launches push_out.
- Simultaneous init and pipeline activity: init wins; push_out=0 from the next cycle and counters read 0.
- reset mid-operation: every output takes its reset value immediately, without waiting for a clock edge.

## Test plan
- Reset, then all queues empty for 10 cycles: state=IDLE, count_valid=1, pop0..3=0, push_out=0, count=0 for idx 0-3.
- Preload queue0 with 0x001 and queue2 with 0x802, release, alm_full_dn=0:
  - pops: pop0 in cycle N, pop2 in cycle N+1.
  - pushes: data_out=0x001 in N+2, 0x802 in N+3.
  - after returning to IDLE: count[0]=1, count[2]=1.
- All four queues hold 3 words each:
  - grant order is 0,1,2,3,0,1,2,3,0,1,2,3 with no idle cycles.
  - after returning to IDLE, each count reads 3.
- Raise alm_full_dn one cycle after pop1: no new pop while it is high, exactly 2 further pushes complete, and arbitration resumes at rr_ptr once it drops.
- Push 33 words through queue3 only:
  - pop3 is high on 33 consecutive cycles.
  - count[3] wraps through 31 -> 0 and reads 1 after returning to IDLE.
- Pulse init during a streaming burst, then pulse reset asynchronously mid-cycle:
  - init: the next state is INIT, in-flight words are not pushed, and all counts read 0.
  - reset: pop and push_out drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tl_egress_merger_if.sv
// Handshake bundle between the four class queues, the merger and the downstream link FIFO.
// The merger attaches through the slave modport; the queue/link environment uses master.
interface tl_egress_merger_if #(
    parameter int unsigned WIDTH = 12
);
    logic             empty0, empty1, empty2, empty3;
    logic [WIDTH-1:0] data_in0, data_in1, data_in2, data_in3;
    logic             pop0, pop1, pop2, pop3;
    logic             alm_full_dn;
    logic             push_out;
    logic [WIDTH-1:0] data_out;

    modport slave (
        input  empty0, empty1, empty2, empty3,
        input  data_in0, data_in1, data_in2, data_in3,
        input  alm_full_dn,
        output pop0, pop1, pop2, pop3,
        output push_out, data_out
    );

    modport master (
        output empty0, empty1, empty2, empty3,
        output data_in0, data_in1, data_in2, data_in3,
        output alm_full_dn,
        input  pop0, pop1, pop2, pop3,
        input  push_out, data_out
    );
endinterface

// File: rtl/tl_egress_merger.sv
// Round-robin merger of four class queues onto one downstream FIFO, with a two-stage
// pop/push pipeline and per-class forwarded-word counters.
module tl_egress_merger #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned CNT_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    tl_egress_merger_if.slave   bus,
    input  logic [1:0]          idx,
    output logic [CNT_W-1:0]    count,
    output logic                count_valid,
    output logic [1:0]          state
);
    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       rr_ptr_q;
    logic             s1_vld_q;
    logic [1:0]       s1_cls_q;
    logic             push_q;
    logic [WIDTH-1:0] dout_q;
    logic [CNT_W-1:0] cnt_q [4];

    logic [3:0]       empty_v;
    logic [WIDTH-1:0] din [4];
    logic             grant_vld;
    logic [1:0]       grant_cls;
    logic [1:0]       cand;

    assign empty_v = {bus.empty3, bus.empty2, bus.empty1, bus.empty0};
    assign din[0]  = bus.data_in0;
    assign din[1]  = bus.data_in1;
    assign din[2]  = bus.data_in2;
    assign din[3]  = bus.data_in3;

    // First non-empty queue at or after rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_cls = rr_ptr_q;
        cand      = rr_ptr_q;
        if (state_q == ST_ACTIVE && !bus.alm_full_dn && !init) begin
            for (int i = 0; i < 4; i++) begin
                cand = rr_ptr_q + 2'(i);
                if (!grant_vld && !empty_v[cand]) begin
                    grant_vld = 1'b1;
                    grant_cls = cand;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = ST_INIT;
        end else begin
            case (state_q)
                ST_INIT:   state_d = ST_IDLE;
                ST_IDLE:   if (!(&empty_v)) state_d = ST_ACTIVE;
                ST_ACTIVE: if ((&empty_v) && !s1_vld_q && !push_q) state_d = ST_IDLE;
                default:   state_d = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_INIT;
            rr_ptr_q <= 2'd0;
            s1_vld_q <= 1'b0;
            s1_cls_q <= 2'd0;
            push_q   <= 1'b0;
            dout_q   <= '0;
            for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
        end else begin
            state_q <= state_d;
            // init discards in-flight words and clears counters on the same edge.
            if (init || state_q == ST_INIT) begin
                rr_ptr_q <= 2'd0;
                s1_vld_q <= 1'b0;
                s1_cls_q <= 2'd0;
                push_q   <= 1'b0;
                for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
            end else begin
                s1_vld_q <= grant_vld;
                s1_cls_q <= grant_cls;
                push_q   <= s1_vld_q;
                if (grant_vld) rr_ptr_q <= grant_cls + 2'd1;
                if (s1_vld_q) begin
                    dout_q          <= din[s1_cls_q];
                    cnt_q[s1_cls_q] <= cnt_q[s1_cls_q] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.pop0     = grant_vld && (grant_cls == 2'd0);
    assign bus.pop1     = grant_vld && (grant_cls == 2'd1);
    assign bus.pop2     = grant_vld && (grant_cls == 2'd2);
    assign bus.pop3     = grant_vld && (grant_cls == 2'd3);
    assign bus.push_out = push_q;
    assign bus.data_out = dout_q;
    assign count        = cnt_q[idx];
    assign count_valid  = (state_q == ST_IDLE);
    assign state        = state_q;
endmodule

// File: tb/tb_tl_egress_merger.sv
// Directed bench for tl_egress_merger: behavioural class queues, cycle tables for
// round-robin and backpressure, hand sequences for wrap, init and async reset.
module tb_tl_egress_merger;
    logic       clk;
    logic       rst;
    logic       init;
    logic [1:0] idx;
    logic [4:0] count;
    logic       count_valid;
    logic [1:0] state;
    logic [3:0] pops;

    tl_egress_merger_if #(.WIDTH(12)) bus ();

    tl_egress_merger #(.WIDTH(12), .CNT_W(5)) dut (
        .clk         (clk),
        .reset       (rst),
        .init        (init),
        .bus         (bus),
        .idx         (idx),
        .count       (count),
        .count_valid (count_valid),
        .state       (state)
    );

    assign pops = {bus.pop3, bus.pop2, bus.pop1, bus.pop0};

    typedef struct {
        logic       alm;
        logic [3:0] pop;
        logic       push;
        logic [11:0] data;
    } vec_t;

    vec_t rr_tab [16];
    vec_t bp_tab [15];

    logic [11:0] mem [4][64];
    int          hd [4];
    int          tl [4];
    logic [11:0] din [4];
    int          n_tests = 0;
    int          n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic upd_empty();
        bus.empty0 = (hd[0] == tl[0]);
        bus.empty1 = (hd[1] == tl[1]);
        bus.empty2 = (hd[2] == tl[2]);
        bus.empty3 = (hd[3] == tl[3]);
    endtask

    task automatic load(input int k, input logic [11:0] w);
        mem[k][tl[k]] = w;
        tl[k]++;
        upd_empty();
    endtask

    // Called at a negedge: commits sampled pops at the next posedge, returns at next negedge.
    task automatic cyc();
        logic [3:0] p;
        p = pops;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (p[k] && hd[k] != tl[k]) begin
                din[k] = mem[k][hd[k]];
                hd[k]++;
            end
        end
        bus.data_in0 = din[0];
        bus.data_in1 = din[1];
        bus.data_in2 = din[2];
        bus.data_in3 = din[3];
        upd_empty();
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (state != 2'd1 && n < budget) begin
            cyc();
            n++;
        end
        chk("reach_idle", 32'(state), 32'd1);
    endtask

    task automatic do_init();
        init = 1'b1;
        cyc();
        init = 1'b0;
        cyc();
    endtask

    task automatic chk_counts(input string tag, input int c0, input int c1, input int c2,
                              input int c3);
        int e [4];
        e = '{c0, c1, c2, c3};
        for (int k = 0; k < 4; k++) begin
            idx = 2'(k);
            #1;
            chk($sformatf("%s_cnt%0d", tag, k), 32'(count), 32'(e[k]));
        end
    endtask

    task automatic apply(input vec_t v, input string tag, input int i);
        bus.alm_full_dn = v.alm;
        #1;
        chk($sformatf("%s[%0d]_pop", tag, i), 32'(pops), 32'(v.pop));
        chk($sformatf("%s[%0d]_push", tag, i), 32'(bus.push_out), 32'(v.push));
        if (v.push) chk($sformatf("%s[%0d]_data", tag, i), 32'(bus.data_out), 32'(v.data));
        cyc();
    endtask

    initial begin
        int run;
        bit broke;

        // Round-robin table: queue k word j = {k, j}; pop at i, push at i+2.
        for (int i = 0; i < 16; i++) begin
            rr_tab[i].alm  = 1'b0;
            rr_tab[i].pop  = (i < 12) ? 4'(1 << (i % 4)) : 4'd0;
            rr_tab[i].push = (i >= 2 && i < 14);
            rr_tab[i].data = rr_tab[i].push ? 12'((((i - 2) % 4) << 10) | ((i - 2) / 4))
                                            : 12'h000;
        end
        // Backpressure: alm_full raised the cycle after pop1, held 4 cycles.
        bp_tab[0]  = '{1'b0, 4'b0001, 1'b0, 12'h000};
        bp_tab[1]  = '{1'b0, 4'b0010, 1'b0, 12'h000};
        bp_tab[2]  = '{1'b1, 4'b0000, 1'b1, 12'h010};
        bp_tab[3]  = '{1'b1, 4'b0000, 1'b1, 12'h410};
        bp_tab[4]  = '{1'b1, 4'b0000, 1'b0, 12'h000};
        bp_tab[5]  = '{1'b1, 4'b0000, 1'b0, 12'h000};
        bp_tab[6]  = '{1'b0, 4'b0100, 1'b0, 12'h000};
        bp_tab[7]  = '{1'b0, 4'b1000, 1'b0, 12'h000};
        bp_tab[8]  = '{1'b0, 4'b0001, 1'b1, 12'h810};
        bp_tab[9]  = '{1'b0, 4'b0010, 1'b1, 12'hC10};
        bp_tab[10] = '{1'b0, 4'b0100, 1'b1, 12'h011};
        bp_tab[11] = '{1'b0, 4'b1000, 1'b1, 12'h411};
        bp_tab[12] = '{1'b0, 4'b0000, 1'b1, 12'h811};
        bp_tab[13] = '{1'b0, 4'b0000, 1'b1, 12'hC11};
        bp_tab[14] = '{1'b0, 4'b0000, 1'b0, 12'h000};

        rst = 1'b1;
        init = 1'b0;
        idx = 2'd0;
        bus.alm_full_dn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            hd[k] = 0;
            tl[k] = 0;
            din[k] = 12'h000;
        end
        bus.data_in0 = 12'h000;
        bus.data_in1 = 12'h000;
        bus.data_in2 = 12'h000;
        bus.data_in3 = 12'h000;
        upd_empty();

        #3;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pop", 32'(pops), 32'd0);
        chk("rst_push", 32'(bus.push_out), 32'd0);
        chk("rst_data", 32'(bus.data_out), 32'd0);
        chk("rst_cvalid", 32'(count_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        chk("idle_state", 32'(state), 32'd1);
        chk("idle_cvalid", 32'(count_valid), 32'd1);
        chk("idle_pop", 32'(pops), 32'd0);
        chk("idle_push", 32'(bus.push_out), 32'd0);
        chk_counts("idle", 0, 0, 0, 0);

        // Two sparse queues.
        load(0, 12'h001);
        load(2, 12'h802);
        cyc();
        chk("two_n0_pop", 32'(pops), 32'b0001);
        chk("two_n0_push", 32'(bus.push_out), 32'd0);
        cyc();
        chk("two_n1_pop", 32'(pops), 32'b0100);
        cyc();
        chk("two_n2_pop", 32'(pops), 32'd0);
        chk("two_n2_push", 32'(bus.push_out), 32'd1);
        chk("two_n2_data", 32'(bus.data_out), 32'h001);
        cyc();
        chk("two_n3_push", 32'(bus.push_out), 32'd1);
        chk("two_n3_data", 32'(bus.data_out), 32'h802);
        cyc();
        chk("two_n4_push", 32'(bus.push_out), 32'd0);
        wait_idle(10);
        chk_counts("two", 1, 0, 1, 0);

        // Full round-robin, three words per class.
        do_init();
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < 4; k++) load(k, 12'((k << 10) | j));
        cyc();
        for (int i = 0; i < 16; i++) apply(rr_tab[i], "rr", i);
        wait_idle(10);
        chk_counts("rr", 3, 3, 3, 3);

        // Backpressure.
        do_init();
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < 4; k++) load(k, 12'((k << 10) | (16 + j)));
        cyc();
        for (int i = 0; i < 15; i++) apply(bp_tab[i], "bp", i);
        wait_idle(10);
        chk_counts("bp", 2, 2, 2, 2);

        // 33 words through queue 3: back-to-back pops and counter wrap.
        do_init();
        for (int j = 0; j < 33; j++) load(3, 12'hC00 | 12'(j));
        cyc();
        idx = 2'd3;
        run = 0;
        broke = 1'b0;
        for (int c = 0; c < 36; c++) begin
            if (c == 32) chk("wrap_cnt31", 32'(count), 32'd31);
            if (c == 33) chk("wrap_cnt0", 32'(count), 32'd0);
            if (pops == 4'b1000 && !broke) run++;
            else broke = 1'b1;
            cyc();
        end
        chk("wrap_pop3_run", 32'(run), 32'd33);
        wait_idle(10);
        idx = 2'd3;
        #1;
        chk("wrap_cnt_final", 32'(count), 32'd1);

        // init during a burst, then asynchronous reset mid-cycle.
        do_init();
        for (int j = 0; j < 4; j++)
            for (int k = 0; k < 4; k++) load(k, 12'((k << 10) | (32 + j)));
        cyc();
        chk("ini_c0_pop", 32'(pops), 32'b0001);
        cyc();
        chk("ini_c1_pop", 32'(pops), 32'b0010);
        cyc();
        chk("ini_c2_push", 32'(bus.push_out), 32'd1);
        cyc();
        init = 1'b1;
        #1;
        chk("ini_c3_pop", 32'(pops), 32'd0);
        chk("ini_c3_data", 32'(bus.data_out), 32'h420);
        cyc();
        chk("ini_c4_state", 32'(state), 32'd0);
        chk("ini_c4_push", 32'(bus.push_out), 32'd0);
        chk_counts("ini", 0, 0, 0, 0);
        init = 1'b0;
        cyc();
        chk("ini_c5_state", 32'(state), 32'd1);
        cyc();
        chk("ini_c6_pop", 32'(pops), 32'b0001);
        cyc();
        cyc();
        chk("ini_c8_push", 32'(bus.push_out), 32'd1);
        chk("ini_c8_data", 32'(bus.data_out), 32'h021);
        chk("ini_c8_pop", 32'(pops), 32'b0100);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pop", 32'(pops), 32'd0);
        chk("arst_push", 32'(bus.push_out), 32'd0);
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_data", 32'(bus.data_out), 32'd0);
        chk("arst_cvalid", 32'(count_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk("arst_rel_state", 32'(state), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
